core_inst_seq: RTL and testbench
================================

// Module: core_inst_seq
// PURPOSE
//  Instruction sequencer that drives the 34-bit inst bus of the core for one
//  weight-stationary tile: weights xmem->L0->array, activations xmem->L0->execute,
//  then drain OFIFO into pmem. It sits beside the core; the testbench or top
//  controller supplies bases/counts and pulses start.
// PARAMETERS
//  COL       8   array columns = weight vectors loaded per tile
//  ADDR_W    11  SRAM address width (2048 words)
//  LOAD_PAD  16  idle cycles after weight load for propagation (>= row+col)
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       begin tile; sampled only in IDLE
//  cfg_w_base   in   ADDR_W  xmem address of first weight vector
//  cfg_a_base   in   ADDR_W  xmem address of first activation vector
//  cfg_p_base   in   ADDR_W  pmem address of first psum
//  cfg_n_act    in   ADDR_W  activation vectors (= psum vectors) in tile
//  ofifo_valid  in   1       core OFIFO holds a complete output row
//  inst         out  34      core instruction word
//  busy         out  1       high from accepted start until done
//  done         out  1       one-cycle pulse at end of tile
// BEHAVIOUR
//  inst fields: [33]acc [32]pmem CEN [31]pmem WEN [30:20]pmem A [19]xmem CEN
//   [18]xmem WEN [17:7]xmem A [6]ofifo_rd [5:4]0 [3]l0_rd [2]l0_wr [1]execute [0]load.
//   CEN/WEN active-low. IDLE_INST = 34'h1_800C_0000 (both SRAMs deselected).
//  Reset: inst=IDLE_INST, busy=0, done=0, state=IDLE, counters 0; reset mid-tile
//   aborts immediately, no partial cycle completes.
//  cfg_* latched on accepted start; changes while busy ignored; start while busy ignored.
//  States (counter i restarts at 0 on each entry):
//   IDLE  : inst=IDLE_INST; start -> WL0, busy=1 next cycle.
//   WL0   : COL+1 cycles. cycle i<COL: xmem read A=w_base+i; cycle i>=1: l0_wr=1
//           (SRAM read latency 1). -> WLOAD.
//   WLOAD : COL cycles l0_rd=1, load=1. -> WPAD.
//   WPAD  : LOAD_PAD cycles IDLE_INST. -> AL0, or DONE if n_act==0.
//   AL0   : n_act+1 cycles, as WL0 with a_base, count n_act. -> EXEC.
//   EXEC  : n_act cycles l0_rd=1, execute=1. -> DRAIN.
//   DRAIN : per cycle ofifo_valid=1: ofifo_rd=1; the following cycle pmem write
//           (CEN=0,WEN=0) A=p_base+j, j++. ofifo_valid=0: no rd, but a pending
//           write still issues. After n_act writes -> ACC (if enabled) else DONE.
//   DONE  : one cycle, done=1, inst=IDLE_INST, busy=0 next cycle; -> IDLE.
//  Addresses are base+offset mod 2^ADDR_W (wrap silently past 2047).
//  Only one SRAM access per SRAM per cycle; all inst bits registered (no comb
//   path from ofifo_valid to inst).
// CONFIGURATION
//  CORE_INST_SEQ_ACC_EN defined: ACC state after DRAIN, n_act cycles pmem read
//   A=p_base+j with inst[33]=1 so SFU accumulates; cfg_acc input (1b) gates it
//   (cfg_acc=0 -> skip to DONE). Undefined: no cfg_acc port, inst[33] tied 0.
// STRUCTURE
//  Package core_inst_seq_pkg: state enum, inst bit-position constants,
//   IDLE_INST, SRAM active-low encodings.
//  Sub-module core_inst_seq_cnt: loadable ADDR_W up-counter with terminal-count
//   flag, reused for phase count and address offset.
// TESTING
//  1 reset low mid-EXEC -> next edge inst=34'h1_800C_0000, busy=0, done=0.
//  2 start, w_base=0x010, n_act=0 -> xmem A 0x010..0x017, 8 l0_wr, 8 load, 16 pad,
//    done exactly 1+9+8+16 cycles after start, no execute.
//  3 a_base=0x7FE, n_act=4 -> xmem reads A=0x7FE,0x7FF,0x000,0x001 (wrap).
//  4 n_act=3, ofifo_valid toggles 1,0,1,0,1 -> 3 ofifo_rd, pmem writes p_base+0..2
//    each one cycle after its rd, done after third write.
//  5 start pulsed during DRAIN with new cfg -> ignored; tile ends with old cfg.
//  6 ACC_EN, cfg_acc=1, n_act=2 -> after DRAIN, 2 pmem reads with inst[33]=1.

Source files
------------

// File: rtl/core_inst_seq_pkg.sv
// Shared types and constants for the core instruction sequencer.
// Defines the inst word bit map, the idle instruction and SRAM encodings.
// No logic; imported by the sequencer top and its counter.
package core_inst_seq_pkg;

    localparam int INST_W = 34;

    // inst word bit positions
    localparam int B_ACC      = 33;
    localparam int B_PM_CEN   = 32;
    localparam int B_PM_WEN   = 31;
    localparam int B_PM_A_HI  = 30;
    localparam int B_PM_A_LO  = 20;
    localparam int B_XM_CEN   = 19;
    localparam int B_XM_WEN   = 18;
    localparam int B_XM_A_HI  = 17;
    localparam int B_XM_A_LO  = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // SRAM control pins are active-low
    localparam logic SRAM_SEL   = 1'b0;
    localparam logic SRAM_DESEL = 1'b1;
    localparam logic SRAM_WR    = 1'b0;
    localparam logic SRAM_RD    = 1'b1;

    // Both SRAMs deselected, every strobe low
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WL0,
        S_WLOAD,
        S_WPAD,
        S_AL0,
        S_EXEC,
        S_DRAIN,
        S_ACC,
        S_DONE
    } state_e;

endpackage

// File: rtl/core_inst_seq_cnt.sv
// Loadable up-counter with terminal-count flag (cnt == last).
// Latency: clr/inc take effect on the next clock; tc is combinational from cnt.
// No backpressure; clr has priority over inc.
module core_inst_seq_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear to zero, else step by one when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == last);

endmodule

// File: rtl/core_inst_seq.sv
// Sequences one weight-stationary tile on the core inst bus (load, execute, drain).
// Latency: inst/busy/done registered, one cycle behind the state that produced them.
// Backpressure: drain reads OFIFO only when ofifo_valid; optional ACC pass via CORE_INST_SEQ_ACC_EN.
module core_inst_seq
    import core_inst_seq_pkg::*;
#(
    parameter int COL      = 8,
    parameter int ADDR_W   = 11,
    parameter int LOAD_PAD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_p_base,
    input  logic [ADDR_W-1:0] cfg_n_act,
`ifdef CORE_INST_SEQ_ACC_EN
    input  logic              cfg_acc,
`endif
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] COL_L      = ADDR_W'(COL);
    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(COL - 1);
    localparam logic [ADDR_W-1:0] PAD_LAST   = ADDR_W'(LOAD_PAD - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   w_base_q, w_base_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;
    logic [ADDR_W-1:0]   p_base_q, p_base_d;
    logic [ADDR_W-1:0]   n_act_q, n_act_d;
    logic                pend_q, pend_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                acc_on;
    logic                rd_go;
    logic                drain_exit;
    logic [ADDR_W-1:0]   n_act_m1;
    logic [ADDR_W-1:0]   i_cnt, i_last, j_cnt;
    logic                i_tc, j_tc, i_clr, i_inc;
    logic [ADDR_W-1:0]   xm_base;

`ifdef CORE_INST_SEQ_ACC_EN
    logic acc_q, acc_d;
    assign acc_on = acc_q;
`else
    assign acc_on = 1'b0;
`endif

    assign n_act_m1 = n_act_q - ADDR_W'(1);

    // Phase counter i: restarts on every state change, doubles as address offset
    assign i_clr = (state_d != state_q);
    assign i_inc = (state_q != S_IDLE);

    core_inst_seq_cnt #(.W(ADDR_W)) u_cnt_phase (
        .clk   (clk),
        .reset (reset),
        .clr   (i_clr),
        .inc   (i_inc),
        .last  (i_last),
        .cnt   (i_cnt),
        .tc    (i_tc)
    );

    // Write counter j: counts pmem writes during DRAIN
    core_inst_seq_cnt #(.W(ADDR_W)) u_cnt_wr (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != S_DRAIN),
        .inc   (pend_q),
        .last  (n_act_m1),
        .cnt   (j_cnt),
        .tc    (j_tc)
    );

    // Reads issued = writes done + pending write, so the last write closes reads
    assign drain_exit = (state_q == S_DRAIN) && pend_q && j_tc;
    assign rd_go      = (state_q == S_DRAIN) && ofifo_valid && !drain_exit;

    // Next state, phase length select and start acceptance
    always_comb begin
        state_d = state_q;
        i_last  = '0;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_WL0;
                end
            end
            S_WL0: begin
                i_last = COL_L;
                if (i_tc) state_d = S_WLOAD;
            end
            S_WLOAD: begin
                i_last = COL_LAST;
                if (i_tc) state_d = S_WPAD;
            end
            S_WPAD: begin
                i_last = PAD_LAST;
                if (i_tc) state_d = (n_act_q == '0) ? S_DONE : S_AL0;
            end
            S_AL0: begin
                i_last = n_act_q;
                if (i_tc) state_d = S_EXEC;
            end
            S_EXEC: begin
                i_last = n_act_m1;
                if (i_tc) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_exit) state_d = acc_on ? S_ACC : S_DONE;
            end
            S_ACC: begin
                i_last = n_act_m1;
                if (i_tc) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Config capture on accepted start, status flags, pending drain write
    always_comb begin
        w_base_d = accept ? cfg_w_base : w_base_q;
        a_base_d = accept ? cfg_a_base : a_base_q;
        p_base_d = accept ? cfg_p_base : p_base_q;
        n_act_d  = accept ? cfg_n_act  : n_act_q;
`ifdef CORE_INST_SEQ_ACC_EN
        acc_d    = accept ? cfg_acc    : acc_q;
`endif
        pend_d   = rd_go;
        busy_d   = accept || (state_q != S_IDLE);
        done_d   = (state_q == S_DONE);
    end

    assign xm_base = (state_q == S_WL0) ? w_base_q : a_base_q;

    // Instruction word for the current state/offset, registered below
    always_comb begin
        inst_d = IDLE_INST;
        unique case (state_q)
            S_WL0, S_AL0: begin
                // SRAM read data lands one cycle later, so L0 write trails by one
                if (!i_tc) begin
                    inst_d[B_XM_CEN]            = SRAM_SEL;
                    inst_d[B_XM_WEN]            = SRAM_RD;
                    inst_d[B_XM_A_HI:B_XM_A_LO] = xm_base + i_cnt;
                end
                if (i_cnt != '0) inst_d[B_L0_WR] = 1'b1;
            end
            S_WLOAD: begin
                inst_d[B_L0_RD] = 1'b1;
                inst_d[B_LOAD]  = 1'b1;
            end
            S_EXEC: begin
                inst_d[B_L0_RD] = 1'b1;
                inst_d[B_EXEC]  = 1'b1;
            end
            S_DRAIN: begin
                if (rd_go) inst_d[B_OFIFO_RD] = 1'b1;
                if (pend_q) begin
                    inst_d[B_PM_CEN]            = SRAM_SEL;
                    inst_d[B_PM_WEN]            = SRAM_WR;
                    inst_d[B_PM_A_HI:B_PM_A_LO] = p_base_q + j_cnt;
                end
            end
`ifdef CORE_INST_SEQ_ACC_EN
            S_ACC: begin
                inst_d[B_ACC]               = 1'b1;
                inst_d[B_PM_CEN]            = SRAM_SEL;
                inst_d[B_PM_WEN]            = SRAM_RD;
                inst_d[B_PM_A_HI:B_PM_A_LO] = p_base_q + i_cnt;
            end
`endif
            default: begin
                inst_d = IDLE_INST;
            end
        endcase
    end

    // State, config and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            w_base_q <= '0;
            a_base_q <= '0;
            p_base_q <= '0;
            n_act_q  <= '0;
`ifdef CORE_INST_SEQ_ACC_EN
            acc_q    <= 1'b0;
`endif
            pend_q   <= 1'b0;
            inst_q   <= IDLE_INST;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_base_q <= w_base_d;
            a_base_q <= a_base_d;
            p_base_q <= p_base_d;
            n_act_q  <= n_act_d;
`ifdef CORE_INST_SEQ_ACC_EN
            acc_q    <= acc_d;
`endif
            pend_q   <= pend_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: reset, weight/activation load, wrap, drain, ignored start.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: drives ofifo_valid from a per-test pattern once execution ends.
module tb_core_inst_seq;

    localparam logic [33:0] IDLE_I = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] cfg_w_base, cfg_a_base, cfg_p_base, cfg_n_act;
`ifdef CORE_INST_SEQ_ACC_EN
    logic        cfg_acc;
`endif
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    logic [10:0] xrd[$], pwr[$], prd[$];
    int          rd_cyc[$], wr_cyc[$];
    int          n_l0wr, n_load, n_exec, n_ofrd, n_noacc, pad_idle, done_cyc;
    bit          ov_pat[$];
    bit          poke;

    core_inst_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_w_base  (cfg_w_base),
        .cfg_a_base  (cfg_a_base),
        .cfg_p_base  (cfg_p_base),
        .cfg_n_act   (cfg_n_act),
`ifdef CORE_INST_SEQ_ACC_EN
        .cfg_acc     (cfg_acc),
`endif
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then record every inst word until done or the cycle budget runs out
    task automatic run_tile(input int max_cyc);
        bit exec_seen;
        bit draining;
        int pidx;
        xrd.delete(); pwr.delete(); prd.delete(); rd_cyc.delete(); wr_cyc.delete();
        n_l0wr = 0; n_load = 0; n_exec = 0; n_ofrd = 0; n_noacc = 0; pad_idle = 0;
        done_cyc = -1; exec_seen = 0; draining = 0; pidx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int k = 1; k <= max_cyc && done_cyc < 0; k++) begin
            tick();
            if (inst[19] == 1'b0) xrd.push_back(inst[17:7]);
            if (inst[2]) n_l0wr++;
            if (inst[0]) n_load++;
            if (inst[1]) begin n_exec++; exec_seen = 1; end
            if (inst[6]) begin n_ofrd++; rd_cyc.push_back(k); end
            if (!inst[32] && !inst[31]) begin pwr.push_back(inst[30:20]); wr_cyc.push_back(k); end
            if (!inst[32] && inst[31]) begin prd.push_back(inst[30:20]); if (!inst[33]) n_noacc++; end
            if (inst == IDLE_I && !done) pad_idle++;
            if (done) done_cyc = k;
            if (exec_seen && !inst[1]) draining = 1;
            if (draining) begin
                ofifo_valid = (pidx < ov_pat.size()) ? ov_pat[pidx] : 1'b1;
                if (poke && pidx == 1) begin
                    start      = 1'b1;
                    cfg_p_base = 11'h3FF;
                    cfg_n_act  = 11'd7;
                end else begin
                    start = 1'b0;
                end
                pidx++;
            end
        end
        ofifo_valid = 1'b0;
        start       = 1'b0;
        check("done_seen", (done_cyc >= 0), 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0; poke = 1'b0;
        cfg_w_base = '0; cfg_a_base = '0; cfg_p_base = '0; cfg_n_act = '0;
`ifdef CORE_INST_SEQ_ACC_EN
        cfg_acc = 1'b0;
`endif
        // Reset state
        tick(); tick();
        check("rst_inst", inst, IDLE_I);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        tick();
        check("idle_inst", inst, IDLE_I);

        // Weights only: w_base 0x010, no activations
        cfg_w_base = 11'h010; cfg_a_base = 11'h100; cfg_p_base = 11'h000; cfg_n_act = 11'd0;
        run_tile(60);
        check("t2_done_cyc", done_cyc, 34);
        check("t2_nxrd", xrd.size(), 8);
        for (int i = 0; i < 8; i++)
            check("t2_xaddr", (xrd.size() > i) ? xrd[i] : 11'h7FF, 11'h010 + 11'(i));
        check("t2_l0wr", n_l0wr, 8);
        check("t2_load", n_load, 8);
        check("t2_exec", n_exec, 0);
        check("t2_pad", pad_idle, 16);
        check("t2_pwr", pwr.size(), 0);
        tick();
        check("t2_busy_off", busy, 0);
        check("t2_done_off", done, 0);

        // Activation address wrap past 2047
        cfg_w_base = 11'h000; cfg_a_base = 11'h7FE; cfg_p_base = 11'h100; cfg_n_act = 11'd4;
        ov_pat.delete();
        run_tile(120);
        check("t3_nxrd", xrd.size(), 12);
        check("t3_a0", (xrd.size() > 8)  ? xrd[8]  : 11'h555, 11'h7FE);
        check("t3_a1", (xrd.size() > 9)  ? xrd[9]  : 11'h555, 11'h7FF);
        check("t3_a2", (xrd.size() > 10) ? xrd[10] : 11'h555, 11'h000);
        check("t3_a3", (xrd.size() > 11) ? xrd[11] : 11'h555, 11'h001);
        check("t3_l0wr", n_l0wr, 12);
        check("t3_exec", n_exec, 4);
        check("t3_nwr", pwr.size(), 4);
        check("t3_p0", (pwr.size() > 0) ? pwr[0] : 11'h555, 11'h100);
        check("t3_p3", (pwr.size() > 3) ? pwr[3] : 11'h555, 11'h103);
        check("t3_prd", prd.size(), 0);
        tick();

        // Gappy OFIFO with a start pulse mid-drain that must be ignored
        cfg_w_base = 11'h020; cfg_a_base = 11'h040; cfg_p_base = 11'h200; cfg_n_act = 11'd3;
        ov_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        poke = 1'b1;
        run_tile(120);
        poke = 1'b0;
        check("t4_nrd", n_ofrd, 3);
        check("t4_nwr", pwr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t4_rd_cyc", (rd_cyc.size() > i) ? rd_cyc[i] : -1, 42 + 2 * i);
            check("t4_wr_cyc", (wr_cyc.size() > i) ? wr_cyc[i] : -1, 43 + 2 * i);
            check("t4_waddr", (pwr.size() > i) ? pwr[i] : 11'h555, 11'h200 + 11'(i));
        end
        check("t4_done_cyc", done_cyc, 48);
        tick();
        check("t5_busy_off", busy, 0);
        tick(); tick();
        check("t5_no_restart", busy, 0);
        check("t5_inst_idle", inst, IDLE_I);

        // Reset asserted mid-EXEC
        cfg_w_base = 11'h000; cfg_a_base = 11'h080; cfg_p_base = 11'h000; cfg_n_act = 11'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!inst[1] && waited < 80) begin
                tick();
                waited++;
            end
            check("t1_exec_reached", inst[1], 1);
        end
        reset = 1'b0;
        #1;
        check("t1_inst_async", inst, IDLE_I);
        tick();
        check("t1_inst", inst, IDLE_I);
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        reset = 1'b1;
        tick(); tick();
        check("t1_stay_idle", inst, IDLE_I);
        check("t1_stay_nbusy", busy, 0);

`ifdef CORE_INST_SEQ_ACC_EN
        // Accumulate pass after drain
        cfg_acc = 1'b1;
        cfg_w_base = 11'h000; cfg_a_base = 11'h010; cfg_p_base = 11'h050; cfg_n_act = 11'd2;
        ov_pat.delete();
        run_tile(120);
        check("t6_nwr", pwr.size(), 2);
        check("t6_nprd", prd.size(), 2);
        check("t6_r0", (prd.size() > 0) ? prd[0] : 11'h555, 11'h050);
        check("t6_r1", (prd.size() > 1) ? prd[1] : 11'h555, 11'h051);
        check("t6_acc_bit", n_noacc, 0);
        cfg_acc = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
